// File: rtl/ex_mul_div_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Stalls IF/ID/EX while a multiply or restoring divide is in flight.
module ex_mul_div_unit #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_BITS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] exInstruction,
  input  logic [31:0] exReg1,
  input  logic [31:0] exReg2,
  input  logic        cancel,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdResult
);

  localparam int unsigned CNT_MAX = (MUL_LATENCY > DIV_BITS) ? MUL_LATENCY : DIV_BITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] counter, counter_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      op_a, op_a_n;   // multiplicand
  logic [31:0]      op_b, op_b_n;   // multiplier / |divisor|
  logic [31:0]      quo, quo_n;     // |dividend| shifting into quotient
  logic [31:0]      rem, rem_n;
  logic             md_signed, md_signed_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;

  logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_multu, is_div, is_divu, start;
  logic unused_bits;

  always_comb begin
    logic is_r;
    is_r     = exInstruction[31:26] == 6'h00;
    is_mfhi  = is_r && exInstruction[5:0] == 6'h10;
    is_mthi  = is_r && exInstruction[5:0] == 6'h11;
    is_mflo  = is_r && exInstruction[5:0] == 6'h12;
    is_mtlo  = is_r && exInstruction[5:0] == 6'h13;
    is_mult  = is_r && exInstruction[5:0] == 6'h18;
    is_multu = is_r && exInstruction[5:0] == 6'h19;
    is_div   = is_r && exInstruction[5:0] == 6'h1A;
    is_divu  = is_r && exInstruction[5:0] == 6'h1B;
    start    = is_mult || is_multu || is_div || is_divu;
  end

  assign unused_bits = ^exInstruction[25:6];

  assign stall = !reset && !cancel &&
                 ((state == S_IDLE && start) || state == S_MUL || state == S_DIV);

  assign mdResult = is_mfhi ? hi : (is_mflo ? lo : 32'h0);

  // Operand magnitudes for the signed divider; DIVU passes operands raw
  logic [31:0] abs_a, abs_b;
  assign abs_a = (is_div && exReg1[31]) ? (~exReg1 + 32'd1) : exReg1;
  assign abs_b = (is_div && exReg2[31]) ? (~exReg2 + 32'd1) : exReg2;

  // Low 64 bits of a 64x64 product are exact for both signed and unsigned operands
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = md_signed ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
  assign mul_b = md_signed ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
  assign prod  = mul_a * mul_b;

  // One restoring-division step
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_step, quo_step, q_final, r_final;
  assign rem_sh   = {rem, quo[31]};
  assign fits     = rem_sh >= {1'b0, op_b};
  assign rem_step = fits ? 32'(rem_sh - {1'b0, op_b}) : rem_sh[31:0];
  assign quo_step = {quo[30:0], fits};
  assign q_final  = neg_q ? (~quo_step + 32'd1) : quo_step;
  assign r_final  = neg_r ? (~rem_step + 32'd1) : rem_step;

  always_comb begin
    state_n     = state;
    counter_n   = counter;
    hi_n        = hi;
    lo_n        = lo;
    op_a_n      = op_a;
    op_b_n      = op_b;
    quo_n       = quo;
    rem_n       = rem;
    md_signed_n = md_signed;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    case (state)
      S_IDLE: begin
        if (!cancel) begin
          if (is_mult || is_multu) begin
            state_n     = S_MUL;
            op_a_n      = exReg1;
            op_b_n      = exReg2;
            md_signed_n = is_mult;
            counter_n   = CNT_W'(MUL_LATENCY - 1);
          end else if (is_div || is_divu) begin
            if (exReg2 == 32'h0) begin
              state_n = S_DONE;
              hi_n    = exReg1;
              lo_n    = 32'hFFFF_FFFF;
            end else begin
              state_n   = S_DIV;
              quo_n     = abs_a;
              op_b_n    = abs_b;
              rem_n     = 32'h0;
              neg_q_n   = is_div && (exReg1[31] ^ exReg2[31]);
              neg_r_n   = is_div && exReg1[31];
              counter_n = CNT_W'(DIV_BITS - 1);
            end
          end else if (is_mthi) begin
            hi_n = exReg1;
          end else if (is_mtlo) begin
            lo_n = exReg1;
          end
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (counter == '0) begin
          hi_n    = prod[63:32];
          lo_n    = prod[31:0];
          state_n = S_DONE;
        end else begin
          counter_n = counter - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else begin
          rem_n = rem_step;
          quo_n = quo_step;
          if (counter == '0) begin
            hi_n    = r_final;
            lo_n    = q_final;
            state_n = S_DONE;
          end else begin
            counter_n = counter - CNT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      hi        <= 32'h0;
      lo        <= 32'h0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      quo       <= 32'h0;
      rem       <= 32'h0;
      md_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      hi        <= hi_n;
      lo        <= lo_n;
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      quo       <= quo_n;
      rem       <= rem_n;
      md_signed <= md_signed_n;
      neg_q     <= neg_q_n;
      neg_r     <= neg_r_n;
    end
  end

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Scoreboard bench for ex_mul_div_unit: expected HI/LO and stall length are
// queued when an op is issued and compared once the op leaves EX.
module tb_ex_mul_div_unit;

  localparam int unsigned MUL_LATENCY = 4;
  localparam int unsigned DIV_BITS    = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        cancel = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] reg1 = 32'h0;
  logic [31:0] reg2 = 32'h0;
  logic        stall;
  logic [31:0] hi, lo, md_result;

  ex_mul_div_unit #(.MUL_LATENCY(MUL_LATENCY), .DIV_BITS(DIV_BITS)) dut (
    .clk(clk), .reset(reset), .exInstruction(instr), .exReg1(reg1), .exReg2(reg2),
    .cancel(cancel), .stall(stall), .hi(hi), .lo(lo), .mdResult(md_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edges;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  // Issue one op, model its effect, and run until the pipeline would release it
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    bit          s, done;
    e.hi = m_hi; e.lo = m_lo; e.edges = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (f)
      F_MULT:  begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; e.edges = int'(MUL_LATENCY) + 1; end
      F_MULTU: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.edges = int'(MUL_LATENCY) + 1; end
      F_DIV, F_DIVU: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.edges = 1;
        end else begin
          if (f == F_DIVU) begin sa = longint'({32'h0, a}); sbv = longint'({32'h0, b}); end
          q = sa / sbv; r = sa % sbv;
          e.lo = 32'(q); e.hi = 32'(r); e.edges = int'(DIV_BITS) + 1;
        end
      end
      F_MTHI: e.hi = a;
      F_MTLO: e.lo = a;
      default: ;
    endcase
    sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    instr = {26'h0, f}; reg1 = a; reg2 = b;
    n = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); s = stall;
      @(negedge clk); #1;
      if (s) begin n++; reg1 = $urandom; reg2 = $urandom; end
      else done = 1;
    end
    instr = 32'h0; reg1 = 32'h0; reg2 = 32'h0;
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(posedge clk); #1 reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_reset_mid_div();
    instr = {26'h0, F_MTHI}; reg1 = 32'hAAAA_0001;
    @(negedge clk); #1;
    instr = {26'h0, F_MTLO}; reg1 = 32'h5555_0002;
    @(negedge clk); #1;
    checks++; if (hi !== 32'hAAAA_0001) begin failures++; $display("FAIL mthi: got %h want %h", hi, 32'hAAAA_0001); end
    checks++; if (lo !== 32'h5555_0002) begin failures++; $display("FAIL mtlo: got %h want %h", lo, 32'h5555_0002); end
    instr = {26'h0, F_DIV}; reg1 = 32'd100; reg2 = 32'd3;
    repeat (22) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL middiv_stall: got %b want 1", stall); end
    #2 reset = 1'b1;
    #1;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL async_reset_hi: got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL async_reset_lo: got %h want %h", lo, 32'h0); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL async_reset_stall: got %b want 0", stall); end
    instr = 32'h0; reg1 = 32'h0; reg2 = 32'h0;
    @(posedge clk); #1 reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk); #1;
    checks++; if (lo !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got lo=%h stall=%b want lo=0 stall=0", lo, stall); end
  endtask

  task automatic test_mul();
    logic [5:0]  fs [7] = '{F_MULT, F_MULTU, F_MULT, F_MULT, F_MULTU, F_MULT, F_MULTU};
    logic [31:0] as [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, $urandom, $urandom};
    logic [31:0] bs [7] = '{32'd7, 32'd2, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom};
    exp_t e; int n;
    for (int i = 0; i < 7; i++) begin
      run_op(fs[i], as[i], bs[i], n);
      e = sb.pop_front();
      checks++; if (n !== e.edges) begin failures++; $display("FAIL mul%0d_stall_edges: got %0d want %0d", i, n, e.edges); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL mul%0d_hi: got %h want %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL mul%0d_lo: got %h want %h", i, lo, e.lo); end
      if (i == 1) begin
        instr = {26'h0, F_MFHI}; #1;
        checks++; if (md_result !== 32'h0000_0001) begin failures++; $display("FAIL mfhi: got %h want %h", md_result, 32'h1); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mfhi_stall: got %b want 0", stall); end
        instr = {26'h0, F_MFLO}; #1;
        checks++; if (md_result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mflo: got %h want %h", md_result, 32'hFFFF_FFFE); end
        instr = 32'h0; #1;
        checks++; if (md_result !== 32'h0) begin failures++; $display("FAIL md_bubble: got %h want 0", md_result); end
      end
    end
  endtask

  task automatic test_div();
    logic [5:0]  fs [8] = '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU};
    logic [31:0] as [8] = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, $urandom, $urandom};
    logic [31:0] bs [8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'h8000_0000, $urandom | 32'd1, $urandom_range(1, 1000)};
    exp_t e; int n;
    for (int i = 0; i < 8; i++) begin
      run_op(fs[i], as[i], bs[i], n);
      e = sb.pop_front();
      checks++; if (n !== e.edges) begin failures++; $display("FAIL div%0d_stall_edges: got %0d want %0d", i, n, e.edges); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL div%0d_hi: got %h want %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL div%0d_lo: got %h want %h", i, lo, e.lo); end
    end
  endtask

  task automatic test_div_boundary();
    logic [5:0]  fs [4] = '{F_DIV, F_DIV, F_DIVU, F_DIV};
    logic [31:0] as [4] = '{32'd5, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000};
    logic [31:0] bs [4] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    exp_t e; int n;
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], as[i], bs[i], n);
      e = sb.pop_front();
      checks++; if (n !== e.edges) begin failures++; $display("FAIL bnd%0d_stall_edges: got %0d want %0d", i, n, e.edges); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL bnd%0d_hi: got %h want %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL bnd%0d_lo: got %h want %h", i, lo, e.lo); end
    end
  endtask

  task automatic test_cancel();
    exp_t e; int n;
    run_op(F_MTLO, 32'h0000_1234, 32'h0, n);
    e = sb.pop_front();
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL cancel_mtlo: got %h want %h", lo, e.lo); end
    // cancel at DIV iteration 5
    instr = {26'h0, F_DIV}; reg1 = 32'd1000; reg2 = 32'd7;
    repeat (6) @(negedge clk);
    #1 cancel = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cancel_div_stall: got %b want 0", stall); end
    @(negedge clk); #1;
    cancel = 1'b0; instr = 32'h0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cancel_div_idle: got stall=%b want 0", stall); end
    checks++; if (lo !== 32'h0000_1234) begin failures++; $display("FAIL cancel_div_lo: got %h want %h", lo, 32'h1234); end
    checks++; if (hi !== m_hi) begin failures++; $display("FAIL cancel_div_hi: got %h want %h", hi, m_hi); end
    run_op(F_DIVU, 32'd9, 32'd2, n);
    e = sb.pop_front();
    checks++; if (n !== e.edges || hi !== e.hi || lo !== e.lo) begin
      failures++; $display("FAIL after_cancel_divu: got edges=%0d hi=%h lo=%h want edges=%0d hi=%h lo=%h", n, hi, lo, e.edges, e.hi, e.lo);
    end
    // cancel on the commit edge of a multiply
    instr = {26'h0, F_MULT}; reg1 = 32'd3; reg2 = 32'd5;
    repeat (4) @(negedge clk);
    #1 cancel = 1'b1;
    @(negedge clk); #1;
    cancel = 1'b0; instr = 32'h0;
    #1;
    checks++; if (hi !== m_hi || lo !== m_lo || stall !== 1'b0) begin
      failures++; $display("FAIL cancel_mul_commit: got hi=%h lo=%h stall=%b want hi=%h lo=%h stall=0", hi, lo, stall, m_hi, m_lo);
    end
    // cancel in IDLE suppresses MTHI and start
    cancel = 1'b1; instr = {26'h0, F_MTHI}; reg1 = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    checks++; if (hi !== m_hi) begin failures++; $display("FAIL cancel_mthi: got %h want %h", hi, m_hi); end
    instr = {26'h0, F_DIV}; reg1 = 32'd5; reg2 = 32'd0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cancel_start_stall: got %b want 0", stall); end
    @(negedge clk); #1;
    cancel = 1'b0; instr = 32'h0; reg1 = 32'h0;
    #1;
    checks++; if (lo !== m_lo || hi !== m_hi) begin failures++; $display("FAIL cancel_start_hilo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_decode();
    instr = 32'h0400_0013; reg1 = 32'hCAFE_F00D;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nonr_stall: got %b want 0", stall); end
    @(negedge clk); #1;
    checks++; if (lo !== m_lo) begin failures++; $display("FAIL nonr_mtlo: got %h want %h", lo, m_lo); end
    instr = 32'h0400_0010; #1;
    checks++; if (md_result !== 32'h0) begin failures++; $display("FAIL nonr_mfhi: got %h want 0", md_result); end
    instr = 32'h0400_0018; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nonr_mult: got %b want 0", stall); end
    instr = 32'h0; reg1 = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] fset [6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
    logic [5:0] f;
    logic [31:0] a, b;
    exp_t e; int n;
    for (int i = 0; i < 10; i++) begin
      f = fset[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      run_op(f, a, b, n);
      e = sb.pop_front();
      checks++; if (n !== e.edges) begin failures++; $display("FAIL b2b%0d_stall_edges: got %0d want %0d", i, n, e.edges); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL b2b%0d_hi: got %h want %h", i, hi, e.hi); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL b2b%0d_lo: got %h want %h", i, lo, e.lo); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_div();
    test_mul();
    test_div();
    test_div_boundary();
    test_cancel();
    test_decode();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
